sntc_ldpc_encoder_ctrl: RTL and testbench
=========================================

SNTC_LDPC_ENCODER_CTRL -- requirements
Module: sntc_ldpc_encoder_ctrl

Interface
REQ-001 SHALL have parameters MM, default 'h0a8, parity bit count.
REQ-002 SHALL have parameters NN, default 'h0d0, codeword bit count; message width is NN-MM (40 at defaults).
REQ-003 SHALL have parameter ENC_LAT, default 2, cycles from encoder input change to a settled valid_cword_enc; legal range >=1.
REQ-004 SHALL have parameter CNT_W, default 16, status counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rstn, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port clr, input, 1, synchronous soft clear.
REQ-008 SHALL have ports msg_valid (input, 1), msg_ready (output, 1) and msg_data (input, NN-MM), the upstream message handshake.
REQ-009 SHALL have ports cw_valid (output, 1), cw_ready (input, 1), cw_data (output, NN) and cw_err (output, 1), the downstream codeword handshake; cw_err flags a failed syndrome check.
REQ-010 SHALL have port enc_msg, output, NN-MM, registered drive to sntc_ldpc_encoder_wrapper y_nr_in_port.
REQ-011 SHALL have ports enc_cword (input, NN, from y_nr_enc) and enc_valid (input, 1, from valid_cword_enc).
REQ-012 SHALL have ports busy (output, 1), cnt_ok (output, CNT_W) and cnt_err (output, CNT_W).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, CHECK and HOLD.
REQ-014 IDLE: msg_ready=1; on msg_valid&msg_ready, latch msg_data into enc_msg, load wait counter with ENC_LAT-1, and go to WAIT.
REQ-015 WAIT: decrement the counter each cycle; when it is 0, go to CHECK, so exactly ENC_LAT cycles elapse between the accept edge and the CHECK cycle.
REQ-016 CHECK (one cycle): cw_data<=enc_cword and cw_err<=~enc_valid; cnt_ok increments if enc_valid, else cnt_err increments; go to HOLD.
REQ-017 HOLD: cw_valid=1; cw_data and cw_err SHALL stay stable until cw_valid&cw_ready.
REQ-018 HOLD handshake without a new message: go to IDLE.
REQ-019 HOLD: msg_ready SHALL equal cw_ready; if msg_valid and cw_ready are both high, accept the new message in the same cycle and go directly to WAIT, giving a back-to-back throughput of one codeword per ENC_LAT+2 cycles.
REQ-020 msg_ready SHALL be 0 in WAIT and CHECK; cw_valid SHALL be 0 outside HOLD.
REQ-021 enc_msg SHALL change only on an accepted message; it holds its value in every other cycle.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 A saturated counter SHALL not affect FSM flow.
REQ-025 clr=1 SHALL force IDLE and zero both counters, cw_valid, cw_err and the wait counter; enc_msg and cw_data SHALL be retained.
REQ-026 While clr=1, msg_ready SHALL be 0, and a message presented in that cycle SHALL be dropped.
REQ-027 A cw_ready with cw_valid=0 SHALL have no effect.
REQ-028 A msg_valid outside IDLE/HOLD SHALL be held off, not lost.

Reset
REQ-029 When rstn=0 at a clock edge: state=IDLE, enc_msg=0, cw_data=0, cw_valid=0, cw_err=0, cnt_ok=0, cnt_err=0, wait counter=0.
REQ-030 Output values after reset: msg_ready=1 from the first cycle after deassertion; busy=0.
REQ-031 rstn SHALL take priority over clr.
REQ-032 Reset asserted mid-operation SHALL abort the in-flight codeword with no counter update.

Structure
REQ-033 The state enum and the MM/NN default constants SHALL live in shared package sntc_ldpc_pkg.
REQ-034 The saturating counter SHALL be one sub-module, sntc_sat_cnt, instantiated twice.
REQ-035 The controller SHALL not instantiate the encoder wrapper; integration is at the level above.

Verification
REQ-036 Single message 40'h12_3456_789A with an enc_valid=1 model -> cw_valid rises ENC_LAT+2 edges after accept, cw_data=model codeword, cw_err=0, cnt_ok=1.
REQ-037 Model forces enc_valid=0 on the CHECK cycle -> cw_err=1, cnt_err=1, cnt_ok unchanged.
REQ-038 cw_ready held 0 for 10 cycles in HOLD -> cw_data/cw_err stable, msg_ready=0, and a pending msg_valid is not accepted until cw_ready=1.
REQ-039 Continuous msg_valid/cw_ready=1 for 8 messages -> 8 codewords in order, one every ENC_LAT+2 cycles, cnt_ok=8.
REQ-040 clr pulse during WAIT -> IDLE next cycle, counters 0, no cw_valid for that message; rstn low in HOLD -> all REQ-029 values.
REQ-041 CNT_W=2 with 5 good codewords -> cnt_ok saturates at 3.

Source files
------------

// File: rtl/sntc_ldpc_pkg.sv
// Shared constants and controller state encoding for the LDPC encoder slice.
package sntc_ldpc_pkg;

  localparam int MM_DEFAULT = 'h0a8;
  localparam int NN_DEFAULT = 'h0d0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/sntc_sat_cnt.sv
// Saturating up-counter with synchronous active-low reset and soft clear.
module sntc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sntc_ldpc_encoder_ctrl.sv
// Handshake controller around the LDPC encoder wrapper: latches a message,
// waits out the encoder latency, captures the codeword and presents it downstream.
module sntc_ldpc_encoder_ctrl
  import sntc_ldpc_pkg::*;
#(
  parameter int MM      = MM_DEFAULT,
  parameter int NN      = NN_DEFAULT,
  parameter int ENC_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [NN-MM-1:0] msg_data,
  output logic             cw_valid,
  input  logic             cw_ready,
  output logic [NN-1:0]    cw_data,
  output logic             cw_err,
  output logic [NN-MM-1:0] enc_msg,
  input  logic [NN-1:0]    enc_cword,
  input  logic             enc_valid,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam int MSG_W  = NN - MM;
  localparam int WAIT_W = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ENC_LAT - 1);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [MSG_W-1:0]  enc_msg_q, enc_msg_d;
  logic [NN-1:0]     cw_data_q, cw_data_d;
  logic              cw_err_q, cw_err_d;
  logic              accept;
  logic              inc_ok;
  logic              inc_err;

  // In HOLD the upstream may only advance when the held codeword leaves.
  assign msg_ready = ~clr & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & cw_ready));
  assign accept    = msg_valid & msg_ready;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    enc_msg_d = enc_msg_q;
    cw_data_d = cw_data_q;
    cw_err_d  = cw_err_q;
    inc_ok    = 1'b0;
    inc_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          enc_msg_d = msg_data;
          wait_d    = WAIT_LOAD;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_CHECK: begin
        cw_data_d = enc_cword;
        cw_err_d  = ~enc_valid;
        inc_ok    = enc_valid;
        inc_err   = ~enc_valid;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (cw_ready) begin
          if (accept) begin
            enc_msg_d = msg_data;
            wait_d    = WAIT_LOAD;
            state_d   = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Soft clear abandons the in-flight codeword but keeps the data registers.
    if (clr) begin
      state_d  = ST_IDLE;
      wait_d   = '0;
      cw_err_d = 1'b0;
      inc_ok   = 1'b0;
      inc_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      enc_msg_q <= '0;
      cw_data_q <= '0;
      cw_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      enc_msg_q <= enc_msg_d;
      cw_data_q <= cw_data_d;
      cw_err_q  <= cw_err_d;
    end
  end

  sntc_sat_cnt #(.W(CNT_W)) u_cnt_ok (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (clr),
    .inc_i (inc_ok),
    .cnt_o (cnt_ok)
  );

  sntc_sat_cnt #(.W(CNT_W)) u_cnt_err (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (clr),
    .inc_i (inc_err),
    .cnt_o (cnt_err)
  );

  assign cw_valid = (state_q == ST_HOLD);
  assign cw_data  = cw_data_q;
  assign cw_err   = cw_err_q;
  assign enc_msg  = enc_msg_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sntc_ldpc_encoder_ctrl.sv
// Directed, table-driven bench for the encoder controller; a second instance
// with a 2-bit status counter shares all inputs to exercise saturation.
module tb_sntc_ldpc_encoder_ctrl;

  localparam int ENC_LAT = 2;
  localparam int NN      = 'h0d0;
  localparam int MW      = 40;

  logic          clk;
  logic          rstn;
  logic          clr;
  logic          msg_valid;
  logic          msg_ready;
  logic [MW-1:0] msg_data;
  logic          cw_valid;
  logic          cw_ready;
  logic [NN-1:0] cw_data;
  logic          cw_err;
  logic [MW-1:0] enc_msg;
  logic [NN-1:0] enc_cword;
  logic          enc_valid;
  logic          busy;
  logic [15:0]   cnt_ok;
  logic [15:0]   cnt_err;

  logic          msg_ready2;
  logic          cw_valid2;
  logic [NN-1:0] cw_data2;
  logic          cw_err2;
  logic [MW-1:0] enc_msg2;
  logic [NN-1:0] enc_cword2;
  logic          busy2;
  logic [1:0]    cnt_ok2;
  logic [1:0]    cnt_err2;

  logic encGood;
  int   vectors;
  int   miscompares;
  int   expOk;
  int   expErr;

  // Stand-in encoder: 168 parity bits derived from the message, message in the low bits.
  function automatic logic [NN-1:0] modelCw(input logic [MW-1:0] m);
    logic [167:0] par;
    par = {m ^ 40'hFF00FF00FF, ~m, m ^ 40'h0123456789, m + 40'd1, m[7:0] ^ 8'h5A};
    return {par, m};
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  assign enc_cword  = modelCw(enc_msg);
  assign enc_cword2 = modelCw(enc_msg2);
  assign enc_valid  = encGood;

  sntc_ldpc_encoder_ctrl #(.ENC_LAT(ENC_LAT), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_err(cw_err),
    .enc_msg(enc_msg), .enc_cword(enc_cword), .enc_valid(enc_valid),
    .busy(busy), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  sntc_ldpc_encoder_ctrl #(.ENC_LAT(ENC_LAT), .CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .clr(clr),
    .msg_valid(msg_valid), .msg_ready(msg_ready2), .msg_data(msg_data),
    .cw_valid(cw_valid2), .cw_ready(cw_ready), .cw_data(cw_data2), .cw_err(cw_err2),
    .enc_msg(enc_msg2), .enc_cword(enc_cword2), .enc_valid(enc_valid),
    .busy(busy2), .cnt_ok(cnt_ok2), .cnt_err(cnt_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  typedef struct {
    logic [MW-1:0] msg;
    logic          good;
    logic          expErrFlag;
    int            expLat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one message and returns the edge count from the accept edge
  // (inclusive) to the first cycle with cw_valid high; 99 means timed out.
  task automatic applyStimulus(input logic [MW-1:0] msg, input logic good, output int lat);
    int n;
    encGood   = good;
    cw_ready  = 1'b0;
    msg_data  = msg;
    msg_valid = 1'b1;
    #1;
    n = 0;
    while (!msg_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    msg_valid = 1'b0;
    lat = 1;
    while (!cw_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!cw_valid) lat = 99;
  endtask

  task automatic drainOne();
    cw_ready = 1'b1;
    tick();
    cw_ready = 1'b0;
    #1;
  endtask

  vec_t          vecs[4];
  logic [MW-1:0] b2bMsgs[8];

  initial begin
    int            lat;
    int            inIdx;
    int            outIdx;
    int            cyc;
    int            lastOut;
    int            orderBad;
    int            spacingBad;
    bit            doIn;
    bit            doOut;
    bit            stable;
    bit            sawValid;
    logic [NN-1:0] heldData;
    logic          heldErr;

    vecs[0] = '{msg: 40'h12_3456_789A, good: 1'b1, expErrFlag: 1'b0, expLat: ENC_LAT + 2};
    vecs[1] = '{msg: 40'h00_0000_0000, good: 1'b1, expErrFlag: 1'b0, expLat: ENC_LAT + 2};
    vecs[2] = '{msg: 40'hFF_FFFF_FFFF, good: 1'b0, expErrFlag: 1'b1, expLat: ENC_LAT + 2};
    vecs[3] = '{msg: 40'hA5_5A5A_A5A5, good: 1'b1, expErrFlag: 1'b0, expLat: ENC_LAT + 2};
    for (int i = 0; i < 8; i++) b2bMsgs[i] = 40'h10_0000_0000 + MW'(i * 40'h1111_1111);

    vectors = 0; miscompares = 0; expOk = 0; expErr = 0;
    rstn = 1'b0; clr = 1'b0; msg_valid = 1'b0; msg_data = '0; cw_ready = 1'b0; encGood = 1'b1;
    tick(); tick();
    rstn = 1'b1;
    #1;
    checkOutput("reset_msg_ready", msg_ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_cw_valid", cw_valid, 1'b0);
    checkOutput("reset_cw_err", cw_err, 1'b0);
    checkOutput("reset_cw_data", cw_data, '0);
    checkOutput("reset_enc_msg", enc_msg, '0);
    checkOutput("reset_cnt_ok", cnt_ok, 16'd0);
    checkOutput("reset_cnt_err", cnt_err, 16'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].msg, vecs[i].good, lat);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d_enc_msg", i), enc_msg, vecs[i].msg);
      checkOutput($sformatf("v%0d_cw_data", i), cw_data, modelCw(vecs[i].msg));
      checkOutput($sformatf("v%0d_cw_err", i), cw_err, vecs[i].expErrFlag);
      checkOutput($sformatf("v%0d_hold_msg_ready", i), msg_ready, 1'b0);
      if (vecs[i].good) expOk++; else expErr++;
      drainOne();
      checkOutput($sformatf("v%0d_cw_valid_after", i), cw_valid, 1'b0);
      checkOutput($sformatf("v%0d_busy_after", i), busy, 1'b0);
      checkOutput($sformatf("v%0d_cnt_ok", i), cnt_ok, expOk);
      checkOutput($sformatf("v%0d_cnt_err", i), cnt_err, expErr);
      checkOutput($sformatf("v%0d_cnt_ok_w2", i), cnt_ok2, sat3(expOk));
    end

    // Downstream stall: a pending message must wait for the held codeword.
    applyStimulus(40'hC0_FFEE_0001, 1'b1, lat);
    heldData  = cw_data;
    heldErr   = cw_err;
    msg_data  = 40'hC0_FFEE_0002;
    msg_valid = 1'b1;
    stable    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cw_data !== heldData || cw_err !== heldErr || msg_ready !== 1'b0 ||
          cw_valid !== 1'b1 || enc_msg !== 40'hC0_FFEE_0001) stable = 1'b0;
    end
    checkOutput("stall_stable", stable, 1'b1);
    checkOutput("stall_cw_data", heldData, modelCw(40'hC0_FFEE_0001));
    cw_ready = 1'b1;
    #1;
    checkOutput("stall_release_msg_ready", msg_ready, 1'b1);
    tick();
    cw_ready  = 1'b0;
    msg_valid = 1'b0;
    checkOutput("stall_accept_enc_msg", enc_msg, 40'hC0_FFEE_0002);
    checkOutput("stall_accept_cw_valid", cw_valid, 1'b0);
    checkOutput("stall_accept_busy", busy, 1'b1);
    lat = 1;
    while (!cw_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("stall_second_latency", lat, ENC_LAT + 2);
    checkOutput("stall_second_cw_data", cw_data, modelCw(40'hC0_FFEE_0002));
    expOk += 2;
    drainOne();
    checkOutput("stall_cnt_ok", cnt_ok, expOk);
    checkOutput("sat_cnt_ok_w2", cnt_ok2, 2'd3);

    // Back-to-back stream with both handshakes held high.
    inIdx = 0; outIdx = 0; cyc = 0; lastOut = -1; orderBad = 0; spacingBad = 0;
    encGood   = 1'b1;
    cw_ready  = 1'b1;
    msg_data  = b2bMsgs[0];
    msg_valid = 1'b1;
    #1;
    while (outIdx < 8 && cyc < 200) begin
      doIn  = msg_valid && msg_ready;
      doOut = cw_valid;
      if (doOut) begin
        if (cw_data !== modelCw(b2bMsgs[outIdx]) || cw_err !== 1'b0) orderBad++;
        if (lastOut >= 0 && (cyc - lastOut) != ENC_LAT + 2) spacingBad++;
        lastOut = cyc;
      end
      tick();
      cyc++;
      if (doOut) outIdx++;
      if (doIn) begin
        inIdx++;
        if (inIdx < 8) msg_data = b2bMsgs[inIdx];
        else msg_valid = 1'b0;
      end
      #1;
    end
    cw_ready = 1'b0;
    msg_valid = 1'b0;
    expOk += 8;
    checkOutput("b2b_count", outIdx, 8);
    checkOutput("b2b_order", orderBad, 0);
    checkOutput("b2b_spacing", spacingBad, 0);
    checkOutput("b2b_cnt_ok", cnt_ok, expOk);
    checkOutput("b2b_cnt_ok_w2", cnt_ok2, 2'd3);

    // Soft clear during WAIT.
    msg_data  = 40'h3C_3C3C_3C3C;
    msg_valid = 1'b1;
    #1;
    tick();
    msg_valid = 1'b0;
    checkOutput("clr_pre_busy", busy, 1'b1);
    clr = 1'b1;
    #1;
    checkOutput("clr_msg_ready", msg_ready, 1'b0);
    tick();
    clr = 1'b0;
    #1;
    checkOutput("clr_busy", busy, 1'b0);
    checkOutput("clr_cnt_ok", cnt_ok, 16'd0);
    checkOutput("clr_cnt_err", cnt_err, 16'd0);
    checkOutput("clr_cnt_ok_w2", cnt_ok2, 2'd0);
    checkOutput("clr_enc_msg_kept", enc_msg, 40'h3C_3C3C_3C3C);
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cw_valid) sawValid = 1'b1;
      tick();
    end
    checkOutput("clr_no_cw_valid", sawValid, 1'b0);
    clr       = 1'b1;
    msg_data  = 40'h77_7777_7777;
    msg_valid = 1'b1;
    tick();
    clr       = 1'b0;
    msg_valid = 1'b0;
    #1;
    checkOutput("clr_drop_enc_msg", enc_msg, 40'h3C_3C3C_3C3C);
    checkOutput("clr_drop_busy", busy, 1'b0);

    // Reset while holding a codeword.
    applyStimulus(40'h5A_0F0F_F0F0, 1'b0, lat);
    checkOutput("rst_pre_cw_valid", cw_valid, 1'b1);
    rstn = 1'b0;
    clr  = 1'b1;
    tick();
    rstn = 1'b1;
    clr  = 1'b0;
    #1;
    checkOutput("rst_cw_valid", cw_valid, 1'b0);
    checkOutput("rst_cw_err", cw_err, 1'b0);
    checkOutput("rst_cw_data", cw_data, '0);
    checkOutput("rst_enc_msg", enc_msg, '0);
    checkOutput("rst_cnt_ok", cnt_ok, 16'd0);
    checkOutput("rst_cnt_err", cnt_err, 16'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_msg_ready", msg_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
